// File: rtl/neuron_pkg.sv
// Shared types and constants for the spike-train encoder datapath.
package neuron_pkg;
  typedef logic [7:0] intensity_t;
  typedef enum logic {ENC_DET = 1'b0, ENC_STOCH = 1'b1} encode_mode_e;
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} enc_state_e;
  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/spike_encoder_lfsr16.sv
// 16-bit Galois LFSR; advances only when en is high, returns to seed on reset.
module lfsr16
  import neuron_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= seed;
    else if (en) q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  end
endmodule

// File: rtl/spike_encoder.sv
// Rate-codes one intensity into a SPIKING_WINDOW-cycle spike train, either by
// phase-accumulator carry (deterministic) or LFSR comparison (stochastic).
module spike_encoder
  import neuron_pkg::*;
#(
  parameter int          SPIKING_WINDOW = 16,
  parameter int          DATA_W         = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int         CW             = $clog2(SPIKING_WINDOW + 1),
  localparam int         YW             = $clog2(SPIKING_WINDOW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic              in_mode,
  output logic              spike_out,
  output logic              window_start,
  output logic              window_done,
  output logic [CW-1:0]     spike_count,
  output logic              busy
);
  localparam logic [YW-1:0] CYC_LAST = YW'(SPIKING_WINDOW - 1);
  localparam logic [YW-1:0] CYC_PEN  = YW'(SPIKING_WINDOW - 2);

  enc_state_e        state, state_nxt;
  logic [YW-1:0]     cyc;
  logic [DATA_W-1:0] acc, value;
  encode_mode_e      mode;
  logic [CW-1:0]     cnt;
  logic [15:0]       lfsr_q;

  logic              last, accept, step, fire, lfsr_en, spike_nxt;
  logic [DATA_W-1:0] cur_v, base;
  encode_mode_e      cur_m;
  logic [DATA_W:0]   sum;

  assign last     = (state == S_RUN) && (cyc == CYC_LAST);
  assign in_ready = (state == S_IDLE) || last;
  assign accept   = in_valid && in_ready;
  assign step     = (state == S_RUN) && !last;
  assign fire     = accept || step;

  // Registered outputs: each edge computes the spike for the window cycle it enters,
  // so an accept edge works from the incoming value with a fresh accumulator.
  assign cur_v     = accept ? in_value : value;
  assign cur_m     = accept ? encode_mode_e'(in_mode) : mode;
  assign base      = accept ? '0 : acc;
  assign sum       = {1'b0, base} + {1'b0, cur_v};
  assign spike_nxt = (cur_m == ENC_STOCH) ? (lfsr_q[DATA_W-1:0] < cur_v) : sum[DATA_W];
  assign lfsr_en   = fire && (cur_m == ENC_STOCH);

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_RUN;
      S_RUN:  if (last && !accept) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cyc          <= '0;
      acc          <= '0;
      value        <= '0;
      mode         <= ENC_DET;
      cnt          <= '0;
      spike_out    <= 1'b0;
      window_start <= 1'b0;
      window_done  <= 1'b0;
      spike_count  <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt == S_RUN);
      window_start <= accept;
      window_done  <= step && (cyc == CYC_PEN);
      if (accept) begin
        value <= in_value;
        mode  <= encode_mode_e'(in_mode);
        cyc   <= '0;
      end else if (step) begin
        cyc <= cyc + 1'b1;
      end else begin
        cyc <= '0;
      end
      if (fire) begin
        spike_out <= spike_nxt;
        acc       <= sum[DATA_W-1:0];
        cnt       <= (accept ? '0 : cnt) + CW'(spike_nxt);
      end else begin
        spike_out <= 1'b0;
      end
      // Total includes the spike of the final window cycle being entered now.
      if (step && (cyc == CYC_PEN))
        spike_count <= cnt + CW'(spike_nxt);
    end
  end
endmodule
